// File: rtl/div32_seq_pkg.sv
// Shared width, latency and FSM encoding for the sequential divider.
package div32_seq_pkg;

  localparam int DATA_WIDTH  = 32;
  // Clock edges from the START sample to the edge that raises DONE.
  localparam int DIV_LATENCY = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div32_seq_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface div32_seq_if
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) ();

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             dbz;

  modport master (output start, signed_op, a, b, input hi, lo, busy, done, dbz);
  modport slave  (input start, signed_op, a, b, output hi, lo, busy, done, dbz);

endinterface

// File: rtl/div32_seq_step.sv
// One combinational restoring step: shift {rem,quo} left, trial-subtract divisor, keep on no borrow.
// Latency: 0 cycles (purely combinational); backpressure: none, driven by the top FSM each CALC cycle.
module div32_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  // The partial remainder never exceeds WIDTH+1 bits, so the top bit of the difference is the borrow.
  assign trial  = rem_sh - {2'b00, dvs_i};
  assign borrow = trial[WIDTH+1];

  assign rem_o = borrow ? rem_sh[WIDTH:0] : trial[WIDTH:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div32_seq.sv
// Sequential restoring divider (DIVU; DIV too when DIV_SIGNED_EN is defined), LO=quotient, HI=remainder.
// Latency: START edge + WIDTH+1 edges to DONE, data independent; START ignored while BUSY, no queuing.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  div32_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d, rem_step;
  logic [WIDTH-1:0] quo_q, quo_d, quo_step;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic             accept, dvs_zero;
  logic [WIDTH-1:0] a_mag, b_mag, hi_fix, lo_fix;

  assign accept   = bus.start & ~busy_q;
  assign dvs_zero = (dvs_q == '0);

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg;
  logic qneg_q, qneg_d, rneg_q, rneg_d;

  assign a_neg = bus.signed_op & bus.a[WIDTH-1];
  assign b_neg = bus.signed_op & bus.b[WIDTH-1];
  assign a_mag = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
  assign b_mag = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;

  // Divide-by-zero keeps the raw all-ones quotient; the remainder fix then restores HI = A.
  assign lo_fix = (qneg_q & ~dvs_zero) ? (~quo_q + WIDTH'(1)) : quo_q;
  assign hi_fix = rneg_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];

  always_comb begin
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (accept) begin
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign a_mag  = bus.a;
  assign b_mag  = bus.b;
  assign lo_fix = quo_q;
  assign hi_fix = rem_q[WIDTH-1:0];
`endif

  div32_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // BUSY stays high through the DONE cycle and drops on the edge after it.
        busy_d = 1'b0;
        if (accept) begin
          state_d = ST_CALC;
          busy_d  = 1'b1;
          cnt_d   = CW'(WIDTH - 1);
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
        end
      end
      ST_CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = hi_fix;
        lo_d    = lo_fix;
        dbz_d   = dvs_zero;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: expected HI/LO/DBZ pushed at START, popped and compared at DONE.
module tb_div32_seq;
  import div32_seq_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  div32_seq_if #(.WIDTH(32)) bus ();

  div32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic sm;
`ifdef DIV_SIGNED_EN
    sm = s;
`else
    sm = s & 1'b0;
`endif
    e.dbz = (b == 32'd0);
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
    end else if (sm && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'd0;
    end else if (sm) begin
      e.lo = $signed(a) / $signed(b);
      e.hi = $signed(a) % $signed(b);
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Presents one request sampled at the next rising edge; returns #1 after that edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.signed_op = s;
    sb.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.signed_op = ~s;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.dbz} !== 67'd0) begin
      fails++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dbz=%b, want all zero",
               bus.hi, bus.lo, bus.busy, bus.done, bus.dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] va[3] = '{32'd100, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] vb[3] = '{32'd7, 32'd1, 32'd10};
    int   cyc;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], 1'b0);
      tests++;
      if (bus.busy !== 1'b1) begin
        fails++;
        $display("FAIL divu_busy_rise[%0d]: busy=%b want 1", i, bus.busy);
      end
      wait_done(cyc);
      e = sb.pop_front();
      tests++;
      if (cyc !== 33) begin
        fails++;
        $display("FAIL divu_latency[%0d]: done after %0d edges, want 33", i, cyc);
      end
      tests++;
      if ({bus.hi, bus.lo, bus.dbz} !== {e.hi, e.lo, e.dbz}) begin
        fails++;
        $display("FAIL divu_result[%0d]: hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 i, bus.hi, bus.lo, bus.dbz, e.hi, e.lo, e.dbz);
      end
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== {e.hi, e.lo, 2'b00}) begin
        fails++;
        $display("FAIL divu_hold[%0d]: hi=%h lo=%h busy=%b done=%b want hi=%h lo=%h idle",
                 i, bus.hi, bus.lo, bus.busy, bus.done, e.hi, e.lo);
      end
    end
  endtask

  // Covers sign rules, divide-by-zero in both modes and the -2^31 / -1 wrap.
  task automatic test_corner_cases();
    logic [31:0] va[8] = '{32'hFFFF_FFF9, 32'd7, 32'd1234, 32'd1234,
                           32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [31:0] vb[8] = '{32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                           32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    logic        vs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int   cyc;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      issue(va[i], vb[i], vs[i]);
      wait_done(cyc);
      e = sb.pop_front();
      tests++;
      if (cyc !== 33) begin
        fails++;
        $display("FAIL corner_latency[%0d]: done after %0d edges, want 33", i, cyc);
      end
      tests++;
      if ({bus.hi, bus.lo, bus.dbz} !== {e.hi, e.lo, e.dbz}) begin
        fails++;
        $display("FAIL corner_result[%0d]: hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 i, bus.hi, bus.lo, bus.dbz, e.hi, e.lo, e.dbz);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        fails++;
        $display("FAIL corner_release[%0d]: busy=%b done=%b want 0 0", i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_start_ignored();
    int   done_cnt = 0;
    int   done_at  = -1;
    logic [64:0] got = '0;
    exp_t e;
    issue(32'd1000, 32'd3, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = c;
        got     = {bus.hi, bus.lo, bus.dbz};
      end
      bus.start = (c == 4 || c == 33);
      bus.a     = 32'd5;
      bus.b     = 32'd1;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    tests++;
    if (done_cnt !== 1 || done_at !== 33) begin
      fails++;
      $display("FAIL ignore_done_count: %0d pulses, last at %0d, want 1 at 33", done_cnt, done_at);
    end
    tests++;
    if (got !== {e.hi, e.lo, e.dbz}) begin
      fails++;
      $display("FAIL ignore_result: got %h want %h", got, {e.hi, e.lo, e.dbz});
    end
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_busy: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int   cyc;
    int   spurious = 0;
    exp_t e;
    // Leave a divide-by-zero result on the outputs so the reset clear is visible.
    issue(32'd1234, 32'd0, 1'b0);
    wait_done(cyc);
    void'(sb.pop_front());
    @(posedge clk);
    issue(32'd999, 32'd4, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    tests++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.dbz} !== 67'd0) begin
      fails++;
      $display("FAIL midreset_clear: hi=%h lo=%h busy=%b done=%b dbz=%b, want all zero",
               bus.hi, bus.lo, bus.busy, bus.done, bus.dbz);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
    end
    tests++;
    if (spurious !== 0) begin
      fails++;
      $display("FAIL midreset_no_done: %0d cycles with done/busy set, want 0", spurious);
    end
    issue(32'hDEAD_BEEF, 32'd17, 1'b0);
    wait_done(cyc);
    e = sb.pop_front();
    tests++;
    if (cyc !== 33 || {bus.hi, bus.lo, bus.dbz} !== {e.hi, e.lo, e.dbz}) begin
      fails++;
      $display("FAIL midreset_fresh_op: %0d edges hi=%h lo=%h dbz=%b want 33 hi=%h lo=%h dbz=%b",
               cyc, bus.hi, bus.lo, bus.dbz, e.hi, e.lo, e.dbz);
    end
    @(posedge clk);
  endtask

  // Requests issued on the first cycle BUSY is low again, operands biased toward edge values.
  task automatic test_back_to_back();
    int          cyc;
    int          bad = 0;
    logic [31:0] a, b;
    logic        s;
    exp_t        e;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       a = 32'($urandom_range(0, 100));
        4:       a = 32'h8000_0000;
        default: ;
      endcase
      issue(a, b, s);
      wait_done(cyc);
      e = sb.pop_front();
      tests++;
      if (cyc !== 33 || {bus.hi, bus.lo, bus.dbz} !== {e.hi, e.lo, e.dbz}) begin
        fails++;
        bad++;
        if (bad <= 5)
          $display("FAIL b2b[%0d] a=%h b=%h s=%b: %0d edges hi=%h lo=%h dbz=%b want 33 hi=%h lo=%h dbz=%b",
                   i, a, b, s, cyc, bus.hi, bus.lo, bus.dbz, e.hi, e.lo, e.dbz);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    test_reset();
    test_unsigned();
    test_corner_cases();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
